// File: rtl/prbs_bit_scheduler.sv
// prbs_bit_scheduler
//   Bit-rate sequencer for the PRBS edge shaper, dac_clk domain.
//   - Fractional phase accumulator produces the one-cycle bit tick.
//   - Selectable Fibonacci LFSR (PRBS7/9/15/23/31) produces the PRBS bit.
//   - Shaping config (edge time, filter) is staged and committed only on
//     bit boundaries so the shaper never sees a change mid-edge.
//   Optional feature: define PRBS_ERR_INJECT_EN to add the err_inject input
//   and the err_count output (single-bit error injection on the next tick).

module prbs_bit_scheduler #(
  parameter int PHASE_W  = 32,
  parameter int MIN_EDGE = 2
) (
  input  logic               dac_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_wr,
  input  logic [PHASE_W-1:0] cfg_bit_inc,
  input  logic [2:0]         cfg_prbs_sel,
  input  logic [7:0]         cfg_edge_time,
  input  logic [1:0]         cfg_filter,
`ifdef PRBS_ERR_INJECT_EN
  input  logic               err_inject,
  output logic [15:0]        err_count,
`endif
  output logic               cfg_ack,
  output logic               lfsr_clk_enable,
  output logic               prbs_bit_out,
  output logic [7:0]         prbs_edge_time_config_reg,
  output logic [1:0]         filter_strength,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam logic [7:0] MIN_EDGE_C = 8'(MIN_EDGE);
  localparam logic [7:0] EDGE_RST   = 8'd16;
  localparam logic [7:0] CNT_MAX    = 8'd255;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_q, inc_d, stg_inc_q, stg_inc_d;
  logic [2:0]         sel_q, sel_d, stg_sel_q, stg_sel_d;
  logic [7:0]         edge_time_q, edge_time_d, stg_edge_q, stg_edge_d;
  logic [1:0]         filter_q, filter_d, stg_filter_q, stg_filter_d;
  logic               pending_q, pending_d;
  logic [30:0]        lfsr_q, lfsr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         period_q, period_d;
  logic [7:0]         edge_out_q, edge_out_d;
  logic               tick_q, tick_d;
  logic               bit_q, bit_d;
  logic               ack_q, ack_d;

  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               fire;
  logic               reseed;
  logic               fb;
  logic [30:0]        lfsr_base;
  logic [2:0]         cap_sel;

`ifdef PRBS_ERR_INJECT_EN
  logic               err_req_q, err_req_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic               flip;
`endif

  // Unsupported selector codes fall back to PRBS7 at capture time.
  assign cap_sel = (cfg_prbs_sel > 3'd4) ? 3'd0 : cfg_prbs_sel;

  // Edge time limited to one clock below the measured bit period, floored at MIN_EDGE.
  function automatic logic [7:0] clamp_edge(input logic [7:0] req, input logic [7:0] period);
    logic [7:0] lim;
    lim = period - 8'd1;
    if (req < lim) lim = req;
    if (lim < MIN_EDGE_C) lim = MIN_EDGE_C;
    return lim;
  endfunction

  // Next-state logic: FSM, accumulator, LFSR, period measurement and config commit.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    acc_d        = acc_q;
    inc_d        = inc_q;
    sel_d        = sel_q;
    edge_time_d  = edge_time_q;
    filter_d     = filter_q;
    stg_inc_d    = stg_inc_q;
    stg_sel_d    = stg_sel_q;
    stg_edge_d   = stg_edge_q;
    stg_filter_d = stg_filter_q;
    pending_d    = pending_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    edge_out_d   = edge_out_q;
    tick_d       = 1'b0;
    bit_d        = bit_q;
    ack_d        = 1'b0;
    sum          = {1'b0, acc_q} + {1'b0, inc_q};
    carry        = sum[PHASE_W];
    fire         = 1'b0;
    reseed       = 1'b0;
    lfsr_base    = lfsr_q;
    fb           = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    err_req_d    = err_req_q | err_inject;
    err_cnt_d    = err_cnt_q;
    flip         = 1'b0;
`endif

    // A write always lands in staging; a later write simply overwrites it.
    if (cfg_wr) begin
      stg_inc_d    = cfg_bit_inc;
      stg_sel_d    = cap_sel;
      stg_edge_d   = cfg_edge_time;
      stg_filter_d = cfg_filter;
      pending_d    = 1'b1;
    end

    case (state_q)
      IDLE, SEED: begin
        // No edge in flight: apply straight away, fresh inputs winning over staging.
        if (cfg_wr) begin
          inc_d       = cfg_bit_inc;
          sel_d       = cap_sel;
          edge_time_d = cfg_edge_time;
          filter_d    = cfg_filter;
        end else if (pending_q) begin
          inc_d       = stg_inc_q;
          sel_d       = stg_sel_q;
          edge_time_d = stg_edge_q;
          filter_d    = stg_filter_q;
        end
        ack_d     = cfg_wr | pending_q;
        pending_d = 1'b0;
        if (state_q == IDLE) begin
          bit_d = 1'b0;
          if (cfg_wr || pending_q) edge_out_d = clamp_edge(edge_time_d, period_q);
          if (enable) state_d = SEED;
        end else begin
          // All-ones across the full register seeds every supported width.
          acc_d   = '0;
          cnt_d   = '0;
          lfsr_d  = '1;
          state_d = RUN;
        end
      end

      default: begin
        acc_d = sum[PHASE_W-1:0];
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        // With a zero increment STOP would never see a carry, so it exits at once.
        fire  = carry || (state_q == STOP && inc_q == '0);
        if (fire) begin
          tick_d   = 1'b1;
          period_d = cnt_d;
          cnt_d    = '0;
          if (pending_q) begin
            reseed      = (stg_sel_q != sel_q);
            inc_d       = stg_inc_q;
            sel_d       = stg_sel_q;
            edge_time_d = stg_edge_q;
            filter_d    = stg_filter_q;
            ack_d       = 1'b1;
            pending_d   = cfg_wr;
          end
          lfsr_base = reseed ? '1 : lfsr_q;
          case (sel_d)
            3'd1:    fb = lfsr_base[8]  ^ lfsr_base[4];
            3'd2:    fb = lfsr_base[14] ^ lfsr_base[13];
            3'd3:    fb = lfsr_base[22] ^ lfsr_base[17];
            3'd4:    fb = lfsr_base[30] ^ lfsr_base[27];
            default: fb = lfsr_base[6]  ^ lfsr_base[5];
          endcase
          lfsr_d     = {lfsr_base[29:0], fb};
          edge_out_d = clamp_edge(edge_time_d, period_d);
          if (state_q == STOP) begin
            bit_d   = 1'b0;
            state_d = IDLE;
          end else begin
`ifdef PRBS_ERR_INJECT_EN
            // Inversion touches only the output bit; the LFSR keeps its true state.
            flip      = err_req_q;
            err_req_d = err_inject;
            if (flip && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            bit_d     = fb ^ flip;
`else
            bit_d     = fb;
`endif
          end
        end
        if (state_q == RUN && !enable) state_d = STOP;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge dac_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      inc_q        <= '0;
      sel_q        <= '0;
      edge_time_q  <= EDGE_RST;
      filter_q     <= '0;
      stg_inc_q    <= '0;
      stg_sel_q    <= '0;
      stg_edge_q   <= '0;
      stg_filter_q <= '0;
      pending_q    <= 1'b0;
      lfsr_q       <= '0;
      cnt_q        <= '0;
      period_q     <= CNT_MAX;
      edge_out_q   <= EDGE_RST;
      tick_q       <= 1'b0;
      bit_q        <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      inc_q        <= inc_d;
      sel_q        <= sel_d;
      edge_time_q  <= edge_time_d;
      filter_q     <= filter_d;
      stg_inc_q    <= stg_inc_d;
      stg_sel_q    <= stg_sel_d;
      stg_edge_q   <= stg_edge_d;
      stg_filter_q <= stg_filter_d;
      pending_q    <= pending_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      edge_out_q   <= edge_out_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      ack_q        <= ack_d;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // Error-injection request latch and saturating flip counter.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      err_req_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_req_q <= err_req_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign cfg_ack                   = ack_q;
  assign lfsr_clk_enable           = tick_q;
  assign prbs_bit_out              = bit_q;
  assign prbs_edge_time_config_reg = edge_out_q;
  assign filter_strength           = filter_q;
  assign state_dbg                 = state_q;

endmodule

// File: tb/tb_prbs_bit_scheduler.sv
// Directed self-checking bench for prbs_bit_scheduler.
// Define PRBS_ERR_INJECT_EN here as well to exercise the error-injection ports.

module tb_prbs_bit_scheduler;

  localparam logic [31:0] INC_Q = 32'h4000_0000;

  logic        dac_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_wr;
  logic [31:0] cfg_bit_inc;
  logic [2:0]  cfg_prbs_sel;
  logic [7:0]  cfg_edge_time;
  logic [1:0]  cfg_filter;
  logic        cfg_ack;
  logic        lfsr_clk_enable;
  logic        prbs_bit_out;
  logic [7:0]  prbs_edge_time_config_reg;
  logic [1:0]  filter_strength;
  logic [1:0]  state_dbg;
`ifdef PRBS_ERR_INJECT_EN
  logic        err_inject;
  logic [15:0] err_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  prbs_bit_scheduler #(.PHASE_W(32), .MIN_EDGE(2)) dut (
    .dac_clk                   (dac_clk),
    .reset                     (reset),
    .enable                    (enable),
    .cfg_wr                    (cfg_wr),
    .cfg_bit_inc               (cfg_bit_inc),
    .cfg_prbs_sel              (cfg_prbs_sel),
    .cfg_edge_time             (cfg_edge_time),
    .cfg_filter                (cfg_filter),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject                (err_inject),
    .err_count                 (err_count),
`endif
    .cfg_ack                   (cfg_ack),
    .lfsr_clk_enable           (lfsr_clk_enable),
    .prbs_bit_out              (prbs_bit_out),
    .prbs_edge_time_config_reg (prbs_edge_time_config_reg),
    .filter_strength           (filter_strength),
    .state_dbg                 (state_dbg)
  );

  always #5 dac_clk = ~dac_clk;

  // Fibonacci reference step: new = s[n-1]^s[k-1], shifted in at bit 0.
  function automatic logic [30:0] ref_step(input logic [30:0] s, input int n, input int k);
    logic f;
    f = s[n-1] ^ s[k-1];
    return {s[29:0], f};
  endfunction

  task automatic step();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic cfg_pulse(input logic [31:0] inc, input logic [2:0] sel,
                           input logic [7:0] et, input logic [1:0] flt);
    cfg_bit_inc   = inc;
    cfg_prbs_sel  = sel;
    cfg_edge_time = et;
    cfg_filter    = flt;
    cfg_wr        = 1'b1;
    step();
    cfg_wr        = 1'b0;
  endtask

  // Steps until the bit tick is seen; an expired budget is a miscompare.
  task automatic wait_tick(input string name, input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (lfsr_clk_enable !== 1'b1 && cyc < budget);
    n_vec++;
    if (lfsr_clk_enable !== 1'b1) begin
      n_err++;
      $display("FAIL %s: no tick within %0d clocks", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; cfg_wr = 1'b0;
    cfg_bit_inc = '0; cfg_prbs_sel = '0; cfg_edge_time = '0; cfg_filter = '0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    #2;
    n_vec++; if (lfsr_clk_enable !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", lfsr_clk_enable); end
    n_vec++; if (prbs_bit_out !== 1'b0) begin n_err++; $display("FAIL rst_bit: got %b want 0", prbs_bit_out); end
    n_vec++; if (cfg_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", cfg_ack); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    n_vec++; if (prbs_edge_time_config_reg !== 8'd16) begin n_err++; $display("FAIL rst_edge: got %0d want 16", prbs_edge_time_config_reg); end
    n_vec++; if (filter_strength !== 2'd0) begin n_err++; $display("FAIL rst_filter: got %0d want 0", filter_strength); end
`ifdef PRBS_ERR_INJECT_EN
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL rst_errcnt: got %0d want 0", err_count); end
`endif
    step(); step();
    @(negedge dac_clk);
    reset = 1'b0;
    step();
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_release_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_idle_clamp();
    cfg_pulse(INC_Q, 3'd0, 8'd40, 2'd0);
    n_vec++; if (cfg_ack !== 1'b1) begin n_err++; $display("FAIL idle_ack: got %b want 1", cfg_ack); end
    n_vec++; if (prbs_edge_time_config_reg !== 8'd40) begin n_err++; $display("FAIL idle_edge40: got %0d want 40", prbs_edge_time_config_reg); end
    cfg_pulse(INC_Q, 3'd0, 8'd1, 2'd0);
    n_vec++; if (prbs_edge_time_config_reg !== 8'd2) begin n_err++; $display("FAIL idle_edge_min: got %0d want 2", prbs_edge_time_config_reg); end
    cfg_pulse(INC_Q, 3'd0, 8'd16, 2'd0);
    n_vec++; if (prbs_edge_time_config_reg !== 8'd16) begin n_err++; $display("FAIL idle_edge16: got %0d want 16", prbs_edge_time_config_reg); end
    step();
    n_vec++; if (cfg_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_pulse: got %b want 0", cfg_ack); end
  endtask

  task automatic test_prbs7();
    logic        got [134];
    logic        exp7 [7];
    logic [30:0] m;
    int          cyc;
    int          bad_gap;
    int          bad_model;
    int          bad_repeat;
    exp7 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    enable = 1'b1;
    step();
    n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL p7_seed_state: got %0d want 1", state_dbg); end
    step();
    n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL p7_run_state: got %0d want 2", state_dbg); end
    wait_tick("p7_first_tick", 20, cyc);
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL p7_first_latency: got %0d want 4", cyc); end
    n_vec++; if (prbs_edge_time_config_reg !== 8'd3) begin n_err++; $display("FAIL p7_edge_clamp: got %0d want 3", prbs_edge_time_config_reg); end
    got[0]  = prbs_bit_out;
    bad_gap = 0;
    for (int i = 1; i < 134; i++) begin
      wait_tick("p7_tick", 20, cyc);
      if (cyc != 4) bad_gap++;
      got[i] = prbs_bit_out;
    end
    n_vec++; if (bad_gap !== 0) begin n_err++; $display("FAIL p7_tick_spacing: got %0d odd gaps want 0", bad_gap); end
    for (int i = 0; i < 7; i++) begin
      n_vec++; if (got[i] !== exp7[i]) begin n_err++; $display("FAIL p7_bit%0d: got %b want %b", i, got[i], exp7[i]); end
    end
    m = '1; bad_model = 0; bad_repeat = 0;
    for (int i = 0; i < 134; i++) begin
      m = ref_step(m, 7, 6);
      if (got[i] !== m[0]) bad_model++;
      if (i >= 127 && got[i] !== got[i-127]) bad_repeat++;
    end
    n_vec++; if (bad_model !== 0) begin n_err++; $display("FAIL p7_sequence: got %0d wrong bits want 0", bad_model); end
    n_vec++; if (bad_repeat !== 0) begin n_err++; $display("FAIL p7_period127: got %0d wrong bits want 0", bad_repeat); end
  endtask

  task automatic test_deferred_commit();
    int cyc;
    wait_tick("dc_sync", 20, cyc);
    step(); step();
    cfg_bit_inc = INC_Q; cfg_prbs_sel = 3'd0; cfg_edge_time = 8'd1; cfg_filter = 2'd3;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    n_vec++; if (cfg_ack !== 1'b0) begin n_err++; $display("FAIL dc_early_ack: got %b want 0", cfg_ack); end
    n_vec++; if (filter_strength !== 2'd0) begin n_err++; $display("FAIL dc_early_filter: got %0d want 0", filter_strength); end
    step();
    n_vec++; if (lfsr_clk_enable !== 1'b1) begin n_err++; $display("FAIL dc_tick: got %b want 1", lfsr_clk_enable); end
    n_vec++; if (cfg_ack !== 1'b1) begin n_err++; $display("FAIL dc_ack: got %b want 1", cfg_ack); end
    n_vec++; if (filter_strength !== 2'd3) begin n_err++; $display("FAIL dc_filter: got %0d want 3", filter_strength); end
    n_vec++; if (prbs_edge_time_config_reg !== 8'd2) begin n_err++; $display("FAIL dc_edge_min: got %0d want 2", prbs_edge_time_config_reg); end
    step();
    n_vec++; if (cfg_ack !== 1'b0) begin n_err++; $display("FAIL dc_ack_pulse: got %b want 0", cfg_ack); end
  endtask

  task automatic test_back_to_back();
    int       cyc;
    int       acks;
    logic [1:0] flt_at_ack;
    wait_tick("bb_sync", 20, cyc);
    cfg_bit_inc = INC_Q; cfg_prbs_sel = 3'd0; cfg_edge_time = 8'd16; cfg_filter = 2'd1;
    cfg_wr = 1'b1;
    step();
    cfg_filter = 2'd2;
    step();
    cfg_wr = 1'b0;
    n_vec++; if (filter_strength !== 2'd3) begin n_err++; $display("FAIL bb_hold_filter: got %0d want 3", filter_strength); end
    acks = 0; flt_at_ack = 2'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cfg_ack === 1'b1) begin acks++; flt_at_ack = filter_strength; end
    end
    n_vec++; if (acks !== 1) begin n_err++; $display("FAIL bb_ack_count: got %0d want 1", acks); end
    n_vec++; if (flt_at_ack !== 2'd2) begin n_err++; $display("FAIL bb_last_value: got %0d want 2", flt_at_ack); end
    n_vec++; if (prbs_edge_time_config_reg !== 8'd3) begin n_err++; $display("FAIL bb_edge: got %0d want 3", prbs_edge_time_config_reg); end
    // Capture landing exactly on a tick edge is deferred to the following tick.
    wait_tick("bb_sync2", 20, cyc);
    step(); step(); step();
    cfg_filter = 2'd1; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    n_vec++; if (lfsr_clk_enable !== 1'b1) begin n_err++; $display("FAIL bb_coinc_tick: got %b want 1", lfsr_clk_enable); end
    n_vec++; if (cfg_ack !== 1'b0) begin n_err++; $display("FAIL bb_coinc_ack: got %b want 0", cfg_ack); end
    n_vec++; if (filter_strength !== 2'd2) begin n_err++; $display("FAIL bb_coinc_filter: got %0d want 2", filter_strength); end
    wait_tick("bb_next_tick", 20, cyc);
    n_vec++; if (cfg_ack !== 1'b1) begin n_err++; $display("FAIL bb_next_ack: got %b want 1", cfg_ack); end
    n_vec++; if (filter_strength !== 2'd1) begin n_err++; $display("FAIL bb_next_filter: got %0d want 1", filter_strength); end
  endtask

  task automatic test_stop();
    int cyc;
    int ticks;
    wait_tick("stop_sync", 20, cyc);
    step();
    enable = 1'b0;
    step();
    n_vec++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL stop_state: got %0d want 3", state_dbg); end
    wait_tick("stop_tick", 20, cyc);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL stop_tick_latency: got %0d want 2", cyc); end
    n_vec++; if (prbs_bit_out !== 1'b0) begin n_err++; $display("FAIL stop_bit: got %b want 0", prbs_bit_out); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL stop_idle: got %0d want 0", state_dbg); end
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (lfsr_clk_enable === 1'b1) ticks++;
    end
    n_vec++; if (ticks !== 0) begin n_err++; $display("FAIL stop_quiet: got %0d ticks want 0", ticks); end
    // Zero increment: STOP leaves on the very next clock.
    cfg_pulse(32'd0, 3'd0, 8'd16, 2'd0);
    enable = 1'b1;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (lfsr_clk_enable === 1'b1) ticks++;
    end
    n_vec++; if (ticks !== 0) begin n_err++; $display("FAIL stop0_no_ticks: got %0d want 0", ticks); end
    enable = 1'b0;
    step();
    n_vec++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL stop0_state: got %0d want 3", state_dbg); end
    step();
    n_vec++; if (lfsr_clk_enable !== 1'b1) begin n_err++; $display("FAIL stop0_tick: got %b want 1", lfsr_clk_enable); end
    n_vec++; if (prbs_bit_out !== 1'b0) begin n_err++; $display("FAIL stop0_bit: got %b want 0", prbs_bit_out); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL stop0_idle: got %0d want 0", state_dbg); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    cfg_pulse(INC_Q, 3'd0, 8'd16, 2'd1);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_tick("rmr_tick", 20, cyc);
      if (prbs_bit_out === 1'b1) break;
    end
    n_vec++; if (prbs_bit_out !== 1'b1) begin n_err++; $display("FAIL rmr_pre_bit: got %b want 1", prbs_bit_out); end
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (lfsr_clk_enable !== 1'b0) begin n_err++; $display("FAIL rmr_tick: got %b want 0", lfsr_clk_enable); end
    n_vec++; if (prbs_bit_out !== 1'b0) begin n_err++; $display("FAIL rmr_bit: got %b want 0", prbs_bit_out); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rmr_state: got %0d want 0", state_dbg); end
    n_vec++; if (filter_strength !== 2'd0) begin n_err++; $display("FAIL rmr_filter: got %0d want 0", filter_strength); end
    n_vec++; if (prbs_edge_time_config_reg !== 8'd16) begin n_err++; $display("FAIL rmr_edge: got %0d want 16", prbs_edge_time_config_reg); end
    enable = 1'b0;
    @(negedge dac_clk);
    reset = 1'b0;
    step();
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rmr_release: got %0d want 0", state_dbg); end
  endtask

  task automatic test_poly_switch();
    int          cyc;
    int          bad_zero;
    logic        got [15];
    logic [30:0] m;
    cfg_pulse(INC_Q, 3'd0, 8'd16, 2'd0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) wait_tick("ps_warm", 20, cyc);
    step();
    cfg_pulse(INC_Q, 3'd2, 8'd16, 2'd0);
    wait_tick("ps_commit", 20, cyc);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL ps_commit_latency: got %0d want 2", cyc); end
    n_vec++; if (cfg_ack !== 1'b1) begin n_err++; $display("FAIL ps_ack: got %b want 1", cfg_ack); end
    got[0] = prbs_bit_out;
    for (int i = 1; i < 15; i++) begin
      wait_tick("ps_tick", 20, cyc);
      got[i] = prbs_bit_out;
    end
    bad_zero = 0;
    for (int i = 0; i < 14; i++) if (got[i] !== 1'b0) bad_zero++;
    n_vec++; if (bad_zero !== 0) begin n_err++; $display("FAIL ps_leading_zeros: got %0d ones want 0", bad_zero); end
    n_vec++; if (got[14] !== 1'b1) begin n_err++; $display("FAIL ps_bit14: got %b want 1", got[14]); end
    m = '1;
    for (int i = 0; i < 15; i++) m = ref_step(m, 15, 14);
`ifdef PRBS_ERR_INJECT_EN
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL ei_count0: got %0d want 0", err_count); end
    step();
    err_inject = 1'b1;
    step(); step();
    err_inject = 1'b0;
    wait_tick("ei_tick", 20, cyc);
    m = ref_step(m, 15, 14);
    n_vec++; if (prbs_bit_out !== ~m[0]) begin n_err++; $display("FAIL ei_flip: got %b want %b", prbs_bit_out, ~m[0]); end
    n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL ei_count1: got %0d want 1", err_count); end
    for (int i = 0; i < 3; i++) begin
      wait_tick("ei_after", 20, cyc);
      m = ref_step(m, 15, 14);
      n_vec++; if (prbs_bit_out !== m[0]) begin n_err++; $display("FAIL ei_clean%0d: got %b want %b", i, prbs_bit_out, m[0]); end
    end
    n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL ei_count_hold: got %0d want 1", err_count); end
`else
    for (int i = 0; i < 4; i++) begin
      wait_tick("ps_cont", 20, cyc);
      m = ref_step(m, 15, 14);
      n_vec++; if (prbs_bit_out !== m[0]) begin n_err++; $display("FAIL ps_cont%0d: got %b want %b", i, prbs_bit_out, m[0]); end
    end
`endif
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_clamp();
    test_prbs7();
    test_deferred_commit();
    test_back_to_back();
    test_stop();
    test_reset_mid_run();
    test_poly_switch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
